vrf_seq: RTL and testbench

Sequencer that drives the vector register file (`vrf`) for one vector operation at a time. It accepts op descriptors (dest, three sources, write-back flag) over a valid/ready handshake. It then walks the vector in beats of `lanes_p` elements and issues per-lane read addresses. Each beat's write-back address and enables are replayed `lat_p` cycles later, after the execute lanes. A compile-time RAW interlock holds off ops that read a register with writes still pending.

---
 rtl/vrf_seq.sv | 151 +++++++++++++++
 tb/tb_vrf_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_seq.sv
// Vector register file sequencer: op handshake, per-beat read issue, and a lat_p-deep write replay pipeline.
// Define VRF_SEQ_HAZARD_EN to hold off ops that read a register with writes still pending (RAW interlock).
module vrf_seq #(
  parameter int els_p   = 32,
  parameter int vlen_p  = 8,
  parameter int lanes_p = 4,
  parameter int lat_p   = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                v_i,
  output logic                                ready_o,
  input  logic [$clog2(els_p)-1:0]            vd_i,
  input  logic [$clog2(els_p)-1:0]            vs0_i,
  input  logic [$clog2(els_p)-1:0]            vs1_i,
  input  logic [$clog2(els_p)-1:0]            vs2_i,
  input  logic                                wb_i,
  output logic [$clog2(els_p)-1:0]            r_reg0_addr_o,
  output logic [$clog2(els_p)-1:0]            r_reg1_addr_o,
  output logic [$clog2(els_p)-1:0]            r_reg2_addr_o,
  output logic [lanes_p*$clog2(vlen_p)-1:0]   r_addr_o,
  output logic                                beat_v_o,
  output logic [$clog2(els_p)-1:0]            w_reg_addr_o,
  output logic [lanes_p*$clog2(vlen_p)-1:0]   w_addr_o,
  output logic [lanes_p-1:0]                  w_en_o,
  output logic                                done_o,
  output logic                                busy_o
);

  localparam int va_lp    = $clog2(els_p);
  localparam int ea_lp    = $clog2(vlen_p);
  localparam int beats_lp = vlen_p / lanes_p;
  localparam int bw_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  typedef struct packed {
    logic             wb;
    logic [va_lp-1:0] vd;
    logic [va_lp-1:0] vs0;
    logic [va_lp-1:0] vs1;
    logic [va_lp-1:0] vs2;
  } desc_t;

  typedef struct packed {
    logic             valid;
    logic             wb;
    logic [va_lp-1:0] vd;
    logic [bw_lp-1:0] b;
    logic             last;
  } stg_t;

  state_e           state_q, state_d;
  logic [bw_lp-1:0] b_q, b_d;
  desc_t            desc_q, desc_d;
  stg_t             stg_q [lat_p];
  stg_t             stg_d [lat_p];

  logic issuing, last_beat, hazard, accept;

  function automatic logic [lanes_p*ea_lp-1:0] lane_addrs(input logic [bw_lp-1:0] b);
    logic [lanes_p*ea_lp-1:0] a;
    a = '0;
    for (int l = 0; l < lanes_p; l++) a[l*ea_lp +: ea_lp] = ea_lp'(int'(b) * lanes_p + l);
    return a;
  endfunction

  function automatic logic src_match(input logic [va_lp-1:0] vd, input logic [va_lp-1:0] s0,
                                     input logic [va_lp-1:0] s1, input logic [va_lp-1:0] s2);
    return (s0 == vd) || (s1 == vd) || (s2 == vd);
  endfunction

  // Handshake, hazard and next-state logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    issuing   = (state_q == ISSUE);
    last_beat = issuing && (b_q == bw_lp'(beats_lp - 1));
    hazard    = 1'b0;
`ifdef VRF_SEQ_HAZARD_EN
    if (issuing && desc_q.wb && src_match(desc_q.vd, vs0_i, vs1_i, vs2_i)) hazard = 1'b1;
    // The last stage is skipped: its write lands before a newly accepted op's first read.
    for (int i = 0; i < lat_p - 1; i++) begin
      if (stg_q[i].valid && stg_q[i].wb && src_match(stg_q[i].vd, vs0_i, vs1_i, vs2_i)) hazard = 1'b1;
    end
`endif
    ready_o = reset_n_i && (!issuing || last_beat) && !hazard;
    accept  = v_i && ready_o;

    state_d = state_q;
    b_d     = b_q;
    desc_d  = desc_q;
    if (accept) begin
      state_d = ISSUE;
      b_d     = '0;
      desc_d  = '{wb: wb_i, vd: vd_i, vs0: vs0_i, vs1: vs1_i, vs2: vs2_i};
    end else if (last_beat) begin
      state_d = IDLE;
      b_d     = '0;
    end else if (issuing) begin
      b_d = b_q + bw_lp'(1);
    end

    stg_d[0] = '{valid: issuing, wb: desc_q.wb, vd: desc_q.vd, b: b_q, last: last_beat};
    for (int i = 1; i < lat_p; i++) stg_d[i] = stg_q[i-1];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!reset_n_i) begin
      state_q <= IDLE;
      b_q     <= '0;
      desc_q  <= '0;
      for (int i = 0; i < lat_p; i++) stg_q[i] <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      desc_q  <= desc_d;
      for (int i = 0; i < lat_p; i++) stg_q[i] <= stg_d[i];
    end
  end

  // Outputs: every address reads 0 whenever its qualifying valid is low.
  always_comb begin
    beat_v_o      = issuing;
    r_reg0_addr_o = '0;
    r_reg1_addr_o = '0;
    r_reg2_addr_o = '0;
    r_addr_o      = '0;
    if (issuing) begin
      r_reg0_addr_o = desc_q.vs0;
      r_reg1_addr_o = desc_q.vs1;
      r_reg2_addr_o = desc_q.vs2;
      r_addr_o      = lane_addrs(b_q);
    end

    w_reg_addr_o = '0;
    w_addr_o     = '0;
    w_en_o       = '0;
    done_o       = 1'b0;
    if (stg_q[lat_p-1].valid) begin
      w_reg_addr_o = stg_q[lat_p-1].vd;
      w_addr_o     = lane_addrs(stg_q[lat_p-1].b);
      w_en_o       = {lanes_p{stg_q[lat_p-1].wb}};
      done_o       = stg_q[lat_p-1].last;
    end

    busy_o = issuing;
    for (int i = 0; i < lat_p; i++) busy_o = busy_o || stg_q[i].valid;
  end

endmodule

// File: tb/tb_vrf_seq.sv
// Self-checking bench for vrf_seq: an op-timeline model checked every cycle, plus directed literal checks.
// Build with or without VRF_SEQ_HAZARD_EN; the bench follows the same macro.
module tb_vrf_seq;

  localparam int els_p   = 32;
  localparam int vlen_p  = 8;
  localparam int lanes_p = 4;
  localparam int lat_p   = 2;
  localparam int va      = 5;
  localparam int ea      = 3;
  localparam int beats   = vlen_p / lanes_p;
  localparam int aw      = lanes_p * ea;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          v_i = 1'b0;
  logic          wb_i = 1'b0;
  logic [va-1:0] vd_i = '0, vs0_i = '0, vs1_i = '0, vs2_i = '0;
  logic          ready_o, beat_v_o, done_o, busy_o;
  logic [va-1:0] r_reg0_addr_o, r_reg1_addr_o, r_reg2_addr_o, w_reg_addr_o;
  logic [aw-1:0] r_addr_o, w_addr_o;
  logic [lanes_p-1:0] w_en_o;

  vrf_seq #(.els_p(els_p), .vlen_p(vlen_p), .lanes_p(lanes_p), .lat_p(lat_p)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
    .vd_i(vd_i), .vs0_i(vs0_i), .vs1_i(vs1_i), .vs2_i(vs2_i), .wb_i(wb_i),
    .r_reg0_addr_o(r_reg0_addr_o), .r_reg1_addr_o(r_reg1_addr_o), .r_reg2_addr_o(r_reg2_addr_o),
    .r_addr_o(r_addr_o), .beat_v_o(beat_v_o), .w_reg_addr_o(w_reg_addr_o), .w_addr_o(w_addr_o),
    .w_en_o(w_en_o), .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Accepted ops, each with the edge number k at which it was taken.
  typedef struct {
    int            k;
    logic [va-1:0] vd, vs0, vs1, vs2;
    logic          wb;
  } op_t;

  typedef struct packed {
    logic          ready, beat_v, done, busy;
    logic [va-1:0] r0, r1, r2, wreg;
    logic [aw-1:0] raddr, waddr;
    logic [lanes_p-1:0] wen;
  } exp_t;

  op_t  ops[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   run_cmp = 1'b0;
  exp_t cmp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [aw-1:0] elems(input int j);
    logic [aw-1:0] r;
    r = '0;
    for (int l = 0; l < lanes_p; l++) r[l*ea +: ea] = ea'(j * lanes_p + l);
    return r;
  endfunction

  // Cycle n lies between edge n-1 and edge n. An op taken at edge k reads in cycles k+1..k+beats
  // and writes in cycles k+1+lat_p..k+beats+lat_p.
  function automatic exp_t model(input int n);
    exp_t e;
    bit   issuing, hazard;
    e = '0;
    issuing = 1'b0;
    hazard  = 1'b0;
    if (!reset_n_i) return e;
    foreach (ops[i]) begin
      int k;
      k = ops[i].k;
      if (n >= k + 1 && n <= k + beats) begin
        e.beat_v = 1'b1;
        e.r0 = ops[i].vs0; e.r1 = ops[i].vs1; e.r2 = ops[i].vs2;
        e.raddr = elems(n - k - 1);
        if (n < k + beats) issuing = 1'b1;
      end
      if (n >= k + 1 + lat_p && n <= k + beats + lat_p) begin
        e.wreg  = ops[i].vd;
        e.waddr = elems(n - k - 1 - lat_p);
        e.wen   = ops[i].wb ? '1 : '0;
        e.done  = (n == k + beats + lat_p);
      end
      if (n > k && n <= k + beats + lat_p) e.busy = 1'b1;
`ifdef VRF_SEQ_HAZARD_EN
      if (ops[i].wb && n < k + beats + lat_p &&
          (vs0_i == ops[i].vd || vs1_i == ops[i].vd || vs2_i == ops[i].vd)) hazard = 1'b1;
`endif
    end
    e.ready = !issuing && !hazard;
    return e;
  endfunction

  always @(negedge clk_i) begin
    if (run_cmp) begin
      cmp_e = model(cyc);
      check("ready_o", ready_o, cmp_e.ready);
      check("beat_v_o", beat_v_o, cmp_e.beat_v);
      check("r_reg0_addr_o", r_reg0_addr_o, cmp_e.r0);
      check("r_reg1_addr_o", r_reg1_addr_o, cmp_e.r1);
      check("r_reg2_addr_o", r_reg2_addr_o, cmp_e.r2);
      check("r_addr_o", r_addr_o, cmp_e.raddr);
      check("w_reg_addr_o", w_reg_addr_o, cmp_e.wreg);
      check("w_addr_o", w_addr_o, cmp_e.waddr);
      check("w_en_o", w_en_o, cmp_e.wen);
      check("done_o", done_o, cmp_e.done);
      check("busy_o", busy_o, cmp_e.busy);
    end
  end

  task automatic drive(input logic v, input logic [va-1:0] vd, input logic [va-1:0] s0,
                       input logic [va-1:0] s1, input logic [va-1:0] s2, input logic wb);
    v_i = v; vd_i = vd; vs0_i = s0; vs1_i = s1; vs2_i = s2; wb_i = wb;
  endtask

  // Advance one edge, recording an accept the model predicts for the cycle just ending.
  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    e = model(cyc);
    if (v_i && e.ready) ops.push_back('{cyc, vd_i, vs0_i, vs1_i, vs2_i, wb_i});
    cyc++;
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic idle_cycles(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  int n0;
  int acc;

  initial begin
    run_cmp = 1'b1;
    mid();
    check("reset ready_o", ready_o, 0);
    check("reset busy_o", busy_o, 0);
    tick();
    tick();
    reset_n_i = 1'b1;
    idle_cycles(2);

    // Single op, vd=5, sources 1/2/3, wb=1.
    drive(1, 5, 1, 2, 3, 1);
    mid(); check("t1 ready", ready_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    mid(); check("t1 c1 r_addr", r_addr_o, 12'h688); check("t1 c1 r_reg0", r_reg0_addr_o, 1);
    tick();
    mid(); check("t1 c2 r_addr", r_addr_o, 12'hFAC);
    tick();
    mid(); check("t1 c3 w_reg", w_reg_addr_o, 5); check("t1 c3 w_addr", w_addr_o, 12'h688);
    check("t1 c3 w_en", w_en_o, 4'hF);
    tick();
    mid(); check("t1 c4 w_addr", w_addr_o, 12'hFAC); check("t1 c4 done", done_o, 1);
    tick();
    mid(); check("t1 c5 busy", busy_o, 0);
    idle_cycles(2);

    // Independent ops back to back: B taken during A's last beat.
    drive(1, 5, 7, 8, 9, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 6, 1, 2, 3, 1);
    mid(); check("t2 c2 ready", ready_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 3; i <= 6; i++) begin
      mid();
      if (i <= 4) check("t2 beat_v", beat_v_o, 1);
      check("t2 w_en", w_en_o, 4'hF);
      tick();
    end
    idle_cycles(2);

    // RAW: B reads vd of A through vs1 and is held valid from cycle 1.
    drive(1, 5, 7, 8, 9, 1);
    tick();
    drive(1, 6, 1, 5, 3, 1);
    n0 = ops.size();
    acc = -1;
    for (int i = 1; i <= 10 && acc < 0; i++) begin
      mid();
`ifdef VRF_SEQ_HAZARD_EN
      if (i == 2 || i == 3) check("t3 ready held", ready_o, 0);
      if (i == 4) check("t3 ready release", ready_o, 1);
`else
      if (i == 2) check("t3 ready", ready_o, 1);
`endif
      tick();
      if (ops.size() > n0) acc = i;
    end
    drive(0, 0, 0, 0, 0, 0);
    if (acc < 0) begin
      n_vec++; n_err++;
      $display("FAIL t3 accept timeout: got none, expected accept within 10 cycles");
    end else begin
`ifdef VRF_SEQ_HAZARD_EN
      check("t3 accept edge", acc, 4);
`else
      check("t3 accept edge", acc, 2);
`endif
      mid(); check("t3 first read beat_v", beat_v_o, 1); check("t3 first read r_reg1", r_reg1_addr_o, 5);
    end
    idle_cycles(5);

    // wb=0 op: no write enables, done still pulses.
    drive(1, 9, 1, 2, 3, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      mid();
      check("t4 w_en", w_en_o, 0);
      if (i == 4) check("t4 done", done_o, 1);
      tick();
    end
    idle_cycles(1);

    // Reset dropped in cycle 2 of a single op.
    drive(1, 5, 1, 2, 3, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset_n_i = 1'b0;
    ops.delete();
    #1;
    check("t5 rst beat_v", beat_v_o, 0); check("t5 rst r_addr", r_addr_o, 0);
    check("t5 rst ready", ready_o, 0); check("t5 rst busy", busy_o, 0);
    tick();
    tick();
    reset_n_i = 1'b1;
    mid(); check("t5 ready after release", ready_o, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      mid(); check("t5 w_en after release", w_en_o, 0);
      tick();
    end

    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
